// File: rtl/biquad_bank_scheduler_pkg.sv
// Shared widths, enums and the output saturation helper for the biquad bank scheduler.
package biquad_pkg;

    localparam int SAMPLE_W = 24;
    localparam int COEF_W   = 32;
    localparam int FRAC     = 20;
    localparam int ACC_W    = 64;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[SAMPLE_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[SAMPLE_W-1:0];
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/biquad_bank_scheduler_if.sv
// Sample, coefficient-write and band-output bundle between the sample source and the filter bank.
interface biquad_bank_scheduler_if
    import biquad_pkg::*;
#(
    parameter int NUM_BANDS = 16
) ();
    localparam int BW = $clog2(NUM_BANDS);

    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid_in;
    logic                       ready_out;
    logic                       overrun_out;
    logic                       coef_we_in;
    logic [BW-1:0]              coef_band_in;
    logic [2:0]                 coef_idx_in;
    logic signed [COEF_W-1:0]   coef_data_in;
    logic                       band_valid_out;
    logic [BW-1:0]              band_idx_out;
    logic signed [SAMPLE_W-1:0] band_sample_out;
    logic                       frame_done_out;

    modport master (
        output sample_in, sample_valid_in, coef_we_in, coef_band_in, coef_idx_in, coef_data_in,
        input  ready_out, overrun_out, band_valid_out, band_idx_out, band_sample_out, frame_done_out
    );

    modport slave (
        input  sample_in, sample_valid_in, coef_we_in, coef_band_in, coef_idx_in, coef_data_in,
        output ready_out, overrun_out, band_valid_out, band_idx_out, band_sample_out, frame_done_out
    );

endinterface

// File: rtl/biquad_bank_scheduler_mac.sv
// Single shared signed multiplier with a registered accumulator; clear_i restarts the sum.
module biquad_mac
    import biquad_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      clear_i,
    input  logic                      acc_en_i,
    input  logic                      sub_i,
    input  logic signed [COEF_W-1:0]   coef_i,
    input  logic signed [SAMPLE_W-1:0] data_i,
    output logic signed [ACC_W-1:0]    acc_o
);
    localparam int PROD_W = COEF_W + SAMPLE_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    assign prod     = coef_i * data_i;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign base     = clear_i ? '0 : acc_q;

    always_comb begin
        acc_d = acc_q;
        if (acc_en_i) begin
            acc_d = sub_i ? (base - prod_ext) : (base + prod_ext);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/biquad_bank_scheduler.sv
// Runs each accepted sample through NUM_BANDS Direct Form I biquads on one shared MAC.
// state | meaning
// IDLE  | ready for a sample and coefficient writes
// MAC   | five products for the current band, phase = coefficient index
// WB    | saturate, register band output, update that band's history
module biquad_bank_scheduler
    import biquad_pkg::*;
#(
    parameter int NUM_BANDS = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    biquad_bank_scheduler_if.slave  bus
);
    localparam int            BW        = $clog2(NUM_BANDS);
    localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);

    state_e    state_q, state_d;
    logic [BW-1:0] band_q, band_d;
    coef_idx_e phase_q, phase_d;
    logic signed [SAMPLE_W-1:0] x_q;

    logic signed [COEF_W-1:0]   coef_q [NUM_BANDS][5];
    logic signed [SAMPLE_W-1:0] x1_q [NUM_BANDS];
    logic signed [SAMPLE_W-1:0] x2_q [NUM_BANDS];
    logic signed [SAMPLE_W-1:0] y1_q [NUM_BANDS];
    logic signed [SAMPLE_W-1:0] y2_q [NUM_BANDS];

    logic                       band_valid_q;
    logic                       frame_done_q;
    logic                       overrun_q;
    logic [BW-1:0]              band_idx_q;
    logic signed [SAMPLE_W-1:0] band_sample_q;

    logic                       accept;
    logic                       wb_en;
    logic                       coef_wr;
    logic                       mac_sub;
    logic signed [COEF_W-1:0]   mac_coef;
    logic signed [SAMPLE_W-1:0] mac_data;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] y_sat;

    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        phase_d = phase_q;
        accept  = 1'b0;
        wb_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_valid_in) begin
                    accept  = 1'b1;
                    band_d  = '0;
                    phase_d = B0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (phase_q == A2) begin
                    phase_d = B0;
                    state_d = WB;
                end else begin
                    phase_d = coef_idx_e'(phase_q + 3'd1);
                end
            end
            WB: begin
                wb_en = 1'b1;
                if (band_q == LAST_BAND) begin
                    state_d = IDLE;
                end else begin
                    band_d  = band_q + 1'b1;
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mac_coef = coef_q[band_q][0];
        mac_data = x_q;
        mac_sub  = 1'b0;
        case (phase_q)
            B1: begin
                mac_coef = coef_q[band_q][1];
                mac_data = x1_q[band_q];
            end
            B2: begin
                mac_coef = coef_q[band_q][2];
                mac_data = x2_q[band_q];
            end
            A1: begin
                mac_coef = coef_q[band_q][3];
                mac_data = y1_q[band_q];
                mac_sub  = 1'b1;
            end
            A2: begin
                mac_coef = coef_q[band_q][4];
                mac_data = y2_q[band_q];
                mac_sub  = 1'b1;
            end
            default: ;
        endcase
    end

    biquad_mac u_mac (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_i  (phase_q == B0),
        .acc_en_i (state_q == MAC),
        .sub_i    (mac_sub),
        .coef_i   (mac_coef),
        .data_i   (mac_data),
        .acc_o    (acc)
    );

    assign y_sat = saturate(acc >>> FRAC);

    // Writes land only while idle so a frame always sees one coefficient set.
    assign coef_wr = bus.coef_we_in && (state_q == IDLE) &&
                     (bus.coef_idx_in <= 3'(A2)) && (bus.coef_band_in <= LAST_BAND);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            band_q        <= '0;
            phase_q       <= B0;
            x_q           <= '0;
            band_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            band_idx_q    <= '0;
            band_sample_q <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                for (int c = 0; c < 5; c++) begin
                    coef_q[b][c] <= '0;
                end
                x1_q[b] <= '0;
                x2_q[b] <= '0;
                y1_q[b] <= '0;
                y2_q[b] <= '0;
            end
        end else begin
            state_q      <= state_d;
            band_q       <= band_d;
            phase_q      <= phase_d;
            band_valid_q <= wb_en;
            frame_done_q <= wb_en && (band_q == LAST_BAND);
            overrun_q    <= bus.sample_valid_in && (state_q != IDLE);
            if (accept) begin
                x_q <= bus.sample_in;
            end
            if (coef_wr) begin
                coef_q[bus.coef_band_in][bus.coef_idx_in] <= bus.coef_data_in;
            end
            if (wb_en) begin
                x2_q[band_q]  <= x1_q[band_q];
                x1_q[band_q]  <= x_q;
                y2_q[band_q]  <= y1_q[band_q];
                y1_q[band_q]  <= y_sat;
                band_idx_q    <= band_q;
                band_sample_q <= y_sat;
            end
        end
    end

    assign bus.ready_out       = (state_q == IDLE);
    assign bus.overrun_out     = overrun_q;
    assign bus.band_valid_out  = band_valid_q;
    assign bus.band_idx_out    = band_idx_q;
    assign bus.band_sample_out = band_sample_q;
    assign bus.frame_done_out  = frame_done_q;

endmodule

// File: doc/biquad_bank_scheduler.md
# biquad_bank_scheduler

Time-multiplexes one shared biquad multiply-accumulate datapath across a bank of NUM_BANDS band filters for the vocoder analysis/synthesis filter bank. Each accepted input sample is run through every band's Direct Form I biquad in sequence, using per-band coefficient and history registers. One filtered sample is emitted per band per frame. The block sits between the audio sample source and the envelope followers, replacing NUM_BANDS parallel biquad instances.

## Interface
- NUM_BANDS, 16, number of band filters in the bank (2..64)
- SAMPLE_W, 24, signed sample width for input, output and history
- COEF_W, 32, signed coefficient width, fixed point with FRAC fractional bits
- FRAC, 20, coefficient fractional bits (1.0 = 1<<20)
- ACC_W, 64, signed accumulator width
---
- clk_in  in  1  system clock; all logic is on the rising edge
- rst_in  in  1  synchronous reset, active-low
- sample_in  in  SAMPLE_W  signed input sample
- sample_valid_in  in  1  sample_in is valid this cycle
- ready_out  out  1  block is idle and will accept a sample
- overrun_out  out  1  one-cycle pulse: sample_valid_in was high while ready_out was low
- coef_we_in  in  1  coefficient write strobe
- coef_band_in  in  $clog2(NUM_BANDS)  target band
- coef_idx_in  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 are ignored
- coef_data_in  in  COEF_W  signed coefficient value
- band_valid_out  out  1  band_sample_out is valid this cycle
- band_idx_out  out  $clog2(NUM_BANDS)  band index of band_sample_out
- band_sample_out  out  SAMPLE_W  filtered, saturated band output
- frame_done_out  out  1  high together with band_valid_out for the last band

## Operation
- Filter equation per band k: y = (b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> FRAC.
  - Products are full precision and summed in ACC_W before the arithmetic shift, so the shift floors the result.
  - The result saturates to signed SAMPLE_W (max 0x7FFFFF, min 0x800000).
- The same x is applied to all bands in a frame.
- After each band's y is computed, that band's history updates: x2←x1, x1←x, y2←y1, y1←y (saturated y).
- FSM states:
  - IDLE: ready_out=1. sample_valid_in=1 latches x, sets band=0, and goes to MAC.
  - MAC: phase counter 0..4 issues one product per cycle in order b0, b1, b2, a1, a2. After phase 4 it goes to WB.
  - WB: shift, saturate, register the outputs, update history. If band=NUM_BANDS−1, go to IDLE; otherwise band+1 and go to MAC.
- Cost is 6 cycles per band and 6·NUM_BANDS cycles per frame.
- A sample_valid_in seen outside IDLE is dropped, overrun_out pulses for 1 cycle, and the frame in progress is unaffected.
- Coefficient writes are accepted only while ready_out=1. Writes while busy are ignored, so coefficients never change mid-frame. A write with coef_idx_in ≥5 is ignored.
- Reset, including a reset mid-frame:
  - All coefficients and history are cleared to 0 and the FSM goes to IDLE.
  - Outputs reset to: ready_out=1, overrun_out=0, band_valid_out=0, frame_done_out=0, band_idx_out=0, band_sample_out=0.
  - A partial frame is discarded with no output.

## Timing
- Accept edge A: the edge where sample_valid_in && ready_out. ready_out falls after A.
- The band k result registers at edge A+6(k+1). band_valid_out, band_idx_out=k and band_sample_out are high/valid for exactly the following cycle.
- band_sample_out holds its value until the next WB.
- The FSM returns to IDLE with the last band's WB. ready_out is high in the same cycle as frame_done_out.
- A sample presented in that cycle is accepted with no bubble, giving a maximum rate of one sample per 6·NUM_BANDS cycles.
- A coefficient write is visible to a frame accepted on the next edge or later. A write and an accept on the same edge: the write takes effect before the frame's first MAC.

## Structure
- Package biquad_pkg holds:
  - SAMPLE_W, COEF_W, FRAC, ACC_W defaults
  - coef index enum {B0, B1, B2, A1, A2}
  - FSM state enum {IDLE, MAC, WB}
  - saturate function (ACC_W to SAMPLE_W)
- Sub-module biquad_mac contains the single signed multiplier and the accumulator, with clear and accumulate controls and a registered accumulator output.
- The top level owns the FSM, the coefficient and history register arrays, and the output registers.

## Test plan
- Reset: hold rst_in=0 for 2 cycles, then release. Require ready_out=1 and all other outputs 0. Feed x=0x020000 with no coefficients written: all band outputs must be 0.
- Identity: band 0 b0=1<<20 and all other coefficients 0. Feed 0x020000, then 0x030000. Require band 0 outputs 0x020000 then 0x030000, valid at A+6 each; bands 1..N−1 output 0.
- Band-pass: band 0 b0=75467, b1=0, b2=−75467, a1=−1237071, a2=937178. Feed impulse 0x020000, then 0. Require band 0 outputs 9433 then 11128; frame_done_out must be high at A+6·NUM_BANDS.
- Saturation: b0=1<<22 (4.0). Input 0x200000 must give output 0x7FFFFF; input 0xE00000 must give output 0x800000.
- Overrun and write gating:
  - Assert sample_valid_in at A+3. Require overrun_out for 1 cycle and an unchanged frame output.
  - Write b0 of band 0 at A+3. Require that the write is ignored: the next frame uses the old b0.
- Mid-frame reset: pull rst_in low at A+20, then release.
  - Require no further band_valid_out and ready_out=1 after release.
  - A fresh impulse must produce a zero-history response, i.e. all coefficients are 0, so all outputs are 0.
